vecmac_seq: RTL



---
 rtl/vecmac_seq.sv | 132 +++++++++++++
 1 files changed

// File: rtl/vecmac_seq.sv
// vecmac_seq: runs one unsigned int8 dot-product job through an external pipelined
// 8x8 multiplier. Operand pairs are pulled over a valid/ready stream and forwarded
// one multiply per accepted pair. Returned products are counted and summed, and done
// pulses with the final sum. The multiplier latency is not assumed; completion is
// detected only by counting returned products.
module vecmac_seq #(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned ACC_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [7:0]       op_a_i,
    input  logic [7:0]       op_b_i,
    output logic             mul_in_valid_o,
    output logic [7:0]       mul_a_o,
    output logic [7:0]       mul_b_o,
    input  logic             mul_out_valid_i,
    input  logic [15:0]      mul_product_i,
    output logic             done_o,
    output logic [ACC_W-1:0] result_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   issued_q, issued_d;
    logic [LEN_W-1:0]   recv_q, recv_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic               accept;

    // Next-state, counter/accumulator updates and handshake outputs.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issued_q;
        recv_d     = recv_q;
        acc_d      = acc_q;
        result_d   = result_q;
        op_ready_o = 1'b0;
        busy_o     = 1'b1;
        done_o     = 1'b0;

        // Products may return during ISSUE as well as DRAIN; outside those they are dropped.
        if ((state_q == StIssue || state_q == StDrain) && mul_out_valid_i) begin
            recv_d = recv_q + LEN_W'(1);
            acc_d  = acc_q + ACC_W'(mul_product_i);
        end

        if (state_q == StIssue) begin
            op_ready_o = (issued_q < len_q);
        end
        accept = op_valid_i && op_ready_o;
        if (accept) begin
            issued_d = issued_q + LEN_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                busy_o = 1'b0;
                if (start_i) begin
                    acc_d = '0;
                    if (len_i == '0) begin
                        result_d = '0;
                        state_d  = StDone;
                    end else begin
                        len_d    = len_i;
                        issued_d = '0;
                        recv_d   = '0;
                        state_d  = StIssue;
                    end
                end
            end
            StIssue: begin
                if (accept && issued_d == len_q) begin
                    // A zero-latency multiplier could complete on the same cycle.
                    if (recv_d == len_q) begin
                        result_d = acc_d;
                        state_d  = StDone;
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (recv_d == len_q) begin
                    result_d = acc_d;
                    state_d  = StDone;
                end
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Issue path is a straight combinational forward of the accepted pair.
    always_comb begin
        mul_in_valid_o = op_valid_i && op_ready_o;
        mul_a_o        = op_a_i;
        mul_b_o        = op_b_i;
        result_o       = result_q;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            len_q    <= '0;
            issued_q <= '0;
            recv_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            recv_q   <= recv_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

endmodule
